// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port plus the decode-side valid/stall handshake.
// The halted status signal exists only when FETCH_HALT_EN is defined.
`timescale 1ns/1ps
interface fetch_unit_if #(
    parameter int unsigned MEM_SPACE = 8,
    parameter int unsigned ISIZE     = 16
);
    logic [MEM_SPACE-1:0] imem_addr;
    logic [ISIZE-1:0]     imem_data;
    logic                 stall;
    logic                 redirect;
    logic [MEM_SPACE-1:0] redirect_pc;
    logic [ISIZE-1:0]     if_instr;
    logic [MEM_SPACE-1:0] if_pc;
    logic                 if_valid;
`ifdef FETCH_HALT_EN
    logic                 halted;
`endif

    // The fetch unit itself.
    modport master (
        output imem_addr,
        output if_instr,
        output if_pc,
        output if_valid,
`ifdef FETCH_HALT_EN
        output halted,
`endif
        input  imem_data,
        input  stall,
        input  redirect,
        input  redirect_pc
    );

    // Memory and decode side.
    modport slave (
        input  imem_addr,
        input  if_instr,
        input  if_pc,
        input  if_valid,
`ifdef FETCH_HALT_EN
        input  halted,
`endif
        output imem_data,
        output stall,
        output redirect,
        output redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, 1-cycle synchronous memory absorption, 1-entry skid buffer, redirects.
// Optional FETCH_HALT_EN: consuming an all-ones instruction halts fetch until redirect or reset.
`timescale 1ns/1ps
module fetch_unit #(
    parameter int unsigned          MEM_SPACE = 8,
    parameter int unsigned          ISIZE     = 16,
    parameter logic [MEM_SPACE-1:0] RESET_PC  = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    // EMPTY: no request in flight; STREAM: data for r_inf_pc on imem_data; HOLD: skid entry full.
    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_STREAM = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [MEM_SPACE-1:0] r_pc;
    logic [MEM_SPACE-1:0] w_pc_nxt;
    logic [MEM_SPACE-1:0] r_inf_pc;
    logic [MEM_SPACE-1:0] w_inf_pc_nxt;
    logic [MEM_SPACE-1:0] r_hold_pc;
    logic [MEM_SPACE-1:0] w_hold_pc_nxt;
    logic [ISIZE-1:0]     r_hold_instr;
    logic [ISIZE-1:0]     w_hold_instr_nxt;

    logic                 w_inf_valid;
    logic                 w_hold_valid;
    logic                 w_out_valid;
    logic                 w_advance;
    logic                 w_if_valid;
    logic [ISIZE-1:0]     w_sel_instr;
    logic [MEM_SPACE-1:0] w_sel_pc;
    logic [MEM_SPACE-1:0] w_pc_inc;

`ifdef FETCH_HALT_EN
    logic                 r_halted;
    logic                 w_halted_nxt;
    logic                 w_halt_hit;
`endif

    assign w_inf_valid  = (r_state != ST_EMPTY);
    assign w_hold_valid = (r_state == ST_HOLD);
    assign w_out_valid  = w_inf_valid | w_hold_valid;
    assign w_advance    = ~bus.stall | ~w_out_valid;
    assign w_pc_inc     = r_pc + MEM_SPACE'(1);

    assign w_sel_instr  = w_hold_valid ? r_hold_instr : bus.imem_data;
    assign w_sel_pc     = w_hold_valid ? r_hold_pc    : r_inf_pc;
    assign w_if_valid   = w_out_valid & ~bus.redirect;

    assign bus.imem_addr = r_pc;
    assign bus.if_valid  = w_if_valid;
    assign bus.if_instr  = w_if_valid ? w_sel_instr : '0;
    assign bus.if_pc     = w_sel_pc;

`ifdef FETCH_HALT_EN
    assign w_halt_hit  = w_if_valid & ~bus.stall & (w_sel_instr == '1);
    assign bus.halted  = r_halted;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_EMPTY;
            r_pc         <= RESET_PC;
            r_inf_pc     <= RESET_PC;
            r_hold_pc    <= RESET_PC;
            r_hold_instr <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_inf_pc     <= w_inf_pc_nxt;
            r_hold_pc    <= w_hold_pc_nxt;
            r_hold_instr <= w_hold_instr_nxt;
        end
    end

`ifdef FETCH_HALT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else begin
            r_halted <= w_halted_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_inf_pc_nxt     = r_inf_pc;
        w_hold_pc_nxt    = r_hold_pc;
        w_hold_instr_nxt = r_hold_instr;
`ifdef FETCH_HALT_EN
        w_halted_nxt     = r_halted;
`endif

        if (bus.redirect) begin
            // Wrong-path kill: in-flight read and skid entry are both dropped.
            w_state_nxt = ST_EMPTY;
            w_pc_nxt    = bus.redirect_pc;
`ifdef FETCH_HALT_EN
            w_halted_nxt = 1'b0;
`endif
        end
`ifdef FETCH_HALT_EN
        else if (r_halted | w_halt_hit) begin
            w_state_nxt  = ST_EMPTY;
            w_halted_nxt = 1'b1;
        end
`endif
        else begin
            w_inf_pc_nxt = r_pc;
            if (w_advance) begin
                w_pc_nxt = w_pc_inc;
            end
            unique case (r_state)
                ST_EMPTY: begin
                    w_state_nxt = ST_STREAM;
                end
                ST_STREAM: begin
                    if (bus.stall) begin
                        w_state_nxt      = ST_HOLD;
                        w_hold_instr_nxt = bus.imem_data;
                        w_hold_pc_nxt    = r_inf_pc;
                    end
                end
                ST_HOLD: begin
                    // While held, memory keeps re-reading r_pc so r_inf_pc stays equal to it.
                    if (!bus.stall) begin
                        w_state_nxt = ST_STREAM;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

endmodule
